anim_frame_scheduler: RTL and testbench

- Owns the animation frame index and ROM frame base address for the POV texture path; replaces the free-running 24 fps frame counter.
- Programmed by the processor through RAM_MMIO with a small register window: play/pause, per-frame period, frame count, playback mode, single-step.
- Can defer frame changes to the next revolution boundary (break-beam tick), so one revolution never shows two frames.

---
 rtl/anim_frame_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_anim_frame_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anim_frame_scheduler.sv
// Animation frame scheduler: MMIO-programmed frame index and ROM frame base generator for the POV texture path.
// Define ANIM_REV_SYNC_EN to let frame changes wait for the next revolution tick (rev_sync, pending, WAIT_REV).
module anim_frame_scheduler #(
   parameter int FRAME_BITS     = 8,
   parameter int FRAME_SIZE     = 13312,
   parameter int BASE_WIDTH     = 19,
   parameter int DEFAULT_PERIOD = 4166667,
   parameter int DEFAULT_FRAMES = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_we,
   input  logic [2:0]            cfg_addr,
   input  logic [31:0]           cfg_wdata,
   output logic [31:0]           cfg_rdata,
   input  logic                  rev_tick,
   output logic [FRAME_BITS-1:0] frame_idx,
   output logic [BASE_WIDTH-1:0] frame_base,
   output logic                  done_pulse
);

`ifdef ANIM_REV_SYNC_EN
   localparam logic REV_SYNC_EN = 1'b1;
`else
   localparam logic REV_SYNC_EN = 1'b0;
`endif

   localparam logic [1:0]            MODE_ONCE = 2'b01;
   localparam logic [1:0]            MODE_PING = 2'b10;
   localparam logic [FRAME_BITS-1:0] IDX_ONE   = FRAME_BITS'(1);
   localparam logic [BASE_WIDTH-1:0] STRIDE    = BASE_WIDTH'(FRAME_SIZE);

   typedef enum logic [1:0] {ST_PAUSED, ST_RUN, ST_WAIT_REV, ST_DONE} state_t;

   logic                  play_q, play_d;
   logic [1:0]            mode_q, mode_d;
   logic                  rev_sync_q, rev_sync_d;
   logic [31:0]           period_q, period_d;
   logic [FRAME_BITS-1:0] nframes_q, nframes_d;
   logic [FRAME_BITS-1:0] frame_idx_q, frame_idx_d;
   logic [BASE_WIDTH-1:0] frame_base_q, frame_base_d;
   logic [31:0]           timer_q, timer_d;
   logic                  pending_q, pending_d;
   logic                  dir_q, dir_d;
   logic                  done_q, done_d;
   logic                  done_pulse_q, done_pulse_d;

   state_t                state;
   logic                  wr_ctrl, wr_period, wr_nframes, wr_step;
   logic [FRAME_BITS-1:0] nframes_new, neff, last;
   logic [31:0]           peff;
   logic                  tick_en, due, imm_adv, rev_adv, step_adv, pend_set, drop, clamp, adv_go;
   logic [FRAME_BITS-1:0] adv_idx, nxt_idx;
   logic [BASE_WIDTH-1:0] adv_base;
   logic                  adv_dir, adv_done, go_down;
   logic [31:0]           status;

   // The scheduler state is a decode of the control flags; done dominates, then play, then pending.
   always_comb begin
      if (done_q)          state = ST_DONE;
      else if (!play_q)    state = ST_PAUSED;
      else if (pending_q)  state = ST_WAIT_REV;
      else                 state = ST_RUN;
   end

   assign wr_ctrl     = cfg_we && (cfg_addr == 3'd0);
   assign wr_period   = cfg_we && (cfg_addr == 3'd1);
   assign wr_nframes  = cfg_we && (cfg_addr == 3'd2);
   assign wr_step     = cfg_we && (cfg_addr == 3'd3);
   assign nframes_new = wr_nframes ? cfg_wdata[FRAME_BITS-1:0] : nframes_q;
   assign neff        = (nframes_new == '0) ? IDX_ONE : nframes_new;
   assign last        = neff - IDX_ONE;
   assign peff        = (period_q == '0) ? 32'd1 : period_q;
   assign tick_en     = REV_SYNC_EN & rev_tick;
   assign due         = (state == ST_RUN) && (timer_q >= peff - 32'd1);
   assign imm_adv     = due && (!rev_sync_q || tick_en);
   assign pend_set    = due && rev_sync_q && !tick_en;
   assign rev_adv     = (state == ST_WAIT_REV) && tick_en;
   assign step_adv    = wr_step && (state == ST_PAUSED);
   assign drop        = wr_ctrl && !cfg_wdata[0] && (due || rev_adv);
   assign clamp       = wr_nframes && (frame_idx_q >= neff);
   assign adv_go      = (imm_adv || rev_adv || step_adv) && !drop && !clamp;

   // Next frame for one advance; the base walks by one stride so no multiplier is needed.
   always_comb begin
      adv_idx  = frame_idx_q;
      adv_base = frame_base_q;
      adv_dir  = dir_q;
      adv_done = 1'b0;
      go_down  = 1'b0;
      nxt_idx  = frame_idx_q;
      if (mode_q == MODE_ONCE) begin
         if (frame_idx_q < last) begin
            adv_idx  = frame_idx_q + IDX_ONE;
            adv_base = frame_base_q + STRIDE;
            adv_done = (adv_idx == last);
         end else begin
            adv_done = 1'b1;
         end
      end else if (mode_q == MODE_PING) begin
         if (last == '0) begin
            adv_idx  = '0;
            adv_base = '0;
            adv_dir  = 1'b0;
         end else begin
            go_down  = dir_q ? (frame_idx_q != '0) : (frame_idx_q >= last);
            nxt_idx  = go_down ? frame_idx_q - IDX_ONE : frame_idx_q + IDX_ONE;
            adv_idx  = nxt_idx;
            adv_base = go_down ? frame_base_q - STRIDE : frame_base_q + STRIDE;
            adv_dir  = (nxt_idx == last) ? 1'b1 : ((nxt_idx == '0) ? 1'b0 : go_down);
         end
      end else begin
         if (frame_idx_q >= last) begin
            adv_idx  = '0;
            adv_base = '0;
         end else begin
            adv_idx  = frame_idx_q + IDX_ONE;
            adv_base = frame_base_q + STRIDE;
         end
      end
   end

   // Register writes are applied last so a pause-drop or an NFRAMES clamp overrides the advance.
   always_comb begin
      play_d       = play_q;
      mode_d       = mode_q;
      rev_sync_d   = rev_sync_q;
      period_d     = period_q;
      nframes_d    = nframes_q;
      frame_idx_d  = frame_idx_q;
      frame_base_d = frame_base_q;
      timer_d      = timer_q;
      pending_d    = pending_q;
      dir_d        = dir_q;
      done_d       = done_q;
      done_pulse_d = 1'b0;

      if (state == ST_RUN)           timer_d = due ? 32'd0 : timer_q + 32'd1;
      else if (state == ST_WAIT_REV) timer_d = 32'd0;

      if (pend_set) pending_d = 1'b1;
      if (rev_adv)  pending_d = 1'b0;
      if (drop)     pending_d = 1'b0;
      if (adv_go) begin
         frame_idx_d  = adv_idx;
         frame_base_d = adv_base;
         dir_d        = adv_dir;
         if (adv_done) begin
            done_d       = 1'b1;
            done_pulse_d = 1'b1;
         end
      end

      if (wr_ctrl) begin
         play_d     = cfg_wdata[0];
         mode_d     = cfg_wdata[2:1];
         rev_sync_d = REV_SYNC_EN & cfg_wdata[3];
         if (done_q && cfg_wdata[0]) begin
            done_d       = 1'b0;
            frame_idx_d  = '0;
            frame_base_d = '0;
            timer_d      = 32'd0;
            dir_d        = 1'b0;
         end else if (done_q && (cfg_wdata[2:1] != MODE_ONCE)) begin
            done_d = 1'b0;
         end
      end
      if (wr_period) begin
         period_d = cfg_wdata;
         timer_d  = 32'd0;
      end
      if (wr_nframes) begin
         nframes_d = cfg_wdata[FRAME_BITS-1:0];
         if (clamp) begin
            frame_idx_d  = '0;
            frame_base_d = '0;
            dir_d        = 1'b0;
            pending_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         play_q       <= 1'b1;
         mode_q       <= 2'b00;
         rev_sync_q   <= 1'b0;
         period_q     <= 32'(DEFAULT_PERIOD);
         nframes_q    <= FRAME_BITS'(DEFAULT_FRAMES);
         frame_idx_q  <= '0;
         frame_base_q <= '0;
         timer_q      <= 32'd0;
         pending_q    <= 1'b0;
         dir_q        <= 1'b0;
         done_q       <= 1'b0;
         done_pulse_q <= 1'b0;
      end else begin
         play_q       <= play_d;
         mode_q       <= mode_d;
         rev_sync_q   <= rev_sync_d;
         period_q     <= period_d;
         nframes_q    <= nframes_d;
         frame_idx_q  <= frame_idx_d;
         frame_base_q <= frame_base_d;
         timer_q      <= timer_d;
         pending_q    <= pending_d;
         dir_q        <= dir_d;
         done_q       <= done_d;
         done_pulse_q <= done_pulse_d;
      end
   end

   always_comb begin
      status                   = '0;
      status[FRAME_BITS-1:0]   = frame_idx_q;
      status[16]               = done_q;
      status[17]               = dir_q;
      status[18]               = pending_q;
      case (cfg_addr)
         3'd0:    cfg_rdata = {28'd0, rev_sync_q, mode_q, play_q};
         3'd1:    cfg_rdata = period_q;
         3'd2:    cfg_rdata = 32'(nframes_q);
         3'd4:    cfg_rdata = status;
         default: cfg_rdata = 32'd0;
      endcase
   end

   assign frame_idx  = frame_idx_q;
   assign frame_base = frame_base_q;
   assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_anim_frame_scheduler.sv
// Self-checking bench for anim_frame_scheduler: reset/register tables, directed playback sequences,
// and a randomized run compared every cycle against a frame-level reference model.
module tb_anim_frame_scheduler;

`ifdef ANIM_REV_SYNC_EN
   localparam bit REV = 1'b1;
`else
   localparam bit REV = 1'b0;
`endif
   localparam int FS = 13312;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;
   logic        rev_tick;
   logic [7:0]  frame_idx;
   logic [18:0] frame_base;
   logic        done_pulse;

   int checks   = 0;
   int failures = 0;

   // Reference model state, kept at the level of "which frame is shown and why".
   bit         mPlay, mSync, mDown, mDone, mPend, mPulse;
   bit [1:0]   mMode;
   longint     mPeriod, mTimer;
   bit [7:0]   mN;
   int         mIdx;

   typedef struct { logic [2:0] addr; logic [31:0] expData; } readVec_t;
   typedef struct { int waitCycles; int expIdx; int expBase; } loopVec_t;

   anim_frame_scheduler dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_rdata(cfg_rdata), .rev_tick(rev_tick), .frame_idx(frame_idx), .frame_base(frame_base),
      .done_pulse(done_pulse)
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      mPlay = 1; mMode = 0; mSync = 0; mPeriod = 4166667; mN = 24;
      mIdx = 0; mDown = 0; mDone = 0; mPend = 0; mTimer = 0; mPulse = 0;
   endtask

   task automatic modelAdvance(input int nEff);
      int last;
      bit goDown;
      last = nEff - 1;
      if (mMode == 2'd1) begin
         if (mIdx < last) mIdx++;
         if (mIdx == last) begin mDone = 1; mPulse = 1; end
      end else if (mMode == 2'd2) begin
         if (last == 0) begin
            mIdx = 0; mDown = 0;
         end else begin
            goDown = mDown ? (mIdx > 0) : (mIdx >= last);
            mIdx = goDown ? mIdx - 1 : mIdx + 1;
            if (mIdx == last)   mDown = 1;
            else if (mIdx == 0) mDown = 0;
            else                mDown = goDown;
         end
      end else begin
         mIdx = (mIdx + 1) % nEff;
      end
   endtask

   task automatic modelStep(input logic we, input logic [2:0] addr, input logic [31:0] data, input logic tick);
      int nEff;
      longint pEff;
      bit running, waiting, paused, due, advance, tickSeen, wrCtrl, wrN, clampNow, oldDone;
      tickSeen = REV && tick;
      wrCtrl   = we && (addr == 3'd0);
      wrN      = we && (addr == 3'd2);
      nEff     = wrN ? int'(data[7:0]) : int'(mN);
      if (nEff == 0) nEff = 1;
      pEff     = (mPeriod == 0) ? 1 : mPeriod;
      running  = mPlay && !mDone && !mPend;
      waiting  = mPlay && !mDone && mPend;
      paused   = !mPlay && !mDone;
      oldDone  = mDone;
      mPulse   = 0;
      due      = 0;
      advance  = 0;
      if (running) begin
         if (mTimer + 1 >= pEff) begin due = 1; mTimer = 0; end
         else mTimer++;
      end else if (waiting) mTimer = 0;
      if (due) begin
         if (mSync && !tickSeen) mPend = 1;
         else advance = 1;
      end
      if (waiting && tickSeen) begin advance = 1; mPend = 0; end
      if (we && addr == 3'd3 && paused) advance = 1;
      if (wrCtrl && !data[0] && (due || (waiting && tickSeen))) begin advance = 0; mPend = 0; end
      clampNow = wrN && (mIdx >= nEff);
      if (advance && !clampNow) modelAdvance(nEff);
      if (wrCtrl) begin
         mPlay = data[0]; mMode = data[2:1]; mSync = REV && data[3];
         if (oldDone && data[0]) begin mDone = 0; mIdx = 0; mTimer = 0; mDown = 0; end
         else if (oldDone && data[2:1] != 2'd1) mDone = 0;
      end
      if (we && addr == 3'd1) begin mPeriod = longint'(data); mTimer = 0; end
      if (wrN) begin
         mN = data[7:0];
         if (clampNow) begin mIdx = 0; mDown = 0; mPend = 0; end
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) modelReset();
      else modelStep(cfg_we, cfg_addr, cfg_wdata, rev_tick);
   end

   function automatic logic [31:0] modelRead(input logic [2:0] addr);
      logic [7:0] idx8;
      idx8 = 8'(mIdx);
      case (addr)
         3'd0:    return {28'd0, mSync, mMode, mPlay};
         3'd1:    return mPeriod[31:0];
         3'd2:    return {24'd0, mN};
         3'd4:    return {13'd0, mPend, mDown, mDone, 8'd0, idx8};
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic checkOutput();
      check("frame_idx", 32'(frame_idx), 32'(mIdx));
      check("frame_base", 32'(frame_base), 32'((mIdx * FS) % 524288));
      check("done_pulse", 32'(done_pulse), 32'(mPulse));
   endtask

   // Drive one cycle from the negedge, check the combinational read, then outputs after the edge.
   task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [31:0] data, input logic tick);
      cfg_we = we; cfg_addr = addr; cfg_wdata = data; rev_tick = tick;
      #1 check("cfg_rdata", cfg_rdata, modelRead(addr));
      @(posedge clk);
      #1 cfg_we = 1'b0; rev_tick = 1'b0;
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd4, 32'd0, 1'b0);
   endtask

   task automatic writeReg(input logic [2:0] addr, input logic [31:0] data);
      applyStimulus(1'b1, addr, data, 1'b0);
   endtask

   task automatic peek(input logic [2:0] addr, output logic [31:0] val);
      cfg_addr = addr;
      #1 val = cfg_rdata;
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      checkOutput();
   endtask

   task automatic setup(input logic [1:0] mode, input logic [31:0] period, input logic [31:0] n, input logic sync);
      doReset();
      writeReg(3'd0, {29'd0, mode, 1'b0});
      writeReg(3'd1, period);
      writeReg(3'd2, n);
      writeReg(3'd0, {28'd0, sync, mode, 1'b1});
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      readVec_t    readTbl[6];
      loopVec_t    loopTbl[5];
      int          ppIdx[5];
      int          ppDir[5];
      logic [31:0] val;
      logic [2:0]  rAddr;
      logic [31:0] rData;
      logic        rWe, rTick;

      readTbl = '{'{3'd0, 32'h1}, '{3'd1, 32'd4166667}, '{3'd2, 32'd24},
                  '{3'd3, 32'd0}, '{3'd4, 32'd0},       '{3'd7, 32'd0}};
      loopTbl = '{'{3, 0, 0}, '{1, 1, 13312}, '{4, 2, 26624}, '{4, 0, 0}, '{4, 1, 13312}};
      ppIdx   = '{1, 2, 1, 0, 1};
      ppDir   = '{0, 1, 1, 0, 0};

      reset = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 32'd0; rev_tick = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset_idx", 32'(frame_idx), 32'd0);
      check("reset_base", 32'(frame_base), 32'd0);
      check("reset_pulse", 32'(done_pulse), 32'd0);
      for (int i = 0; i < 6; i++) begin
         peek(readTbl[i].addr, val);
         check($sformatf("reset_read_a%0d", readTbl[i].addr), val, readTbl[i].expData);
      end
      @(negedge clk);
      idle(20);
      check("reset_no_early_adv", 32'(frame_idx), 32'd0);

      $display("[TB] LOOP N=3 P=4");
      setup(2'd0, 32'd4, 32'd3, 1'b0);
      for (int i = 0; i < 5; i++) begin
         idle(loopTbl[i].waitCycles);
         check($sformatf("loop_idx_%0d", i), 32'(frame_idx), 32'(loopTbl[i].expIdx));
         check($sformatf("loop_base_%0d", i), 32'(frame_base), 32'(loopTbl[i].expBase));
      end

      $display("[TB] ONCE N=3 P=2");
      setup(2'd1, 32'd2, 32'd3, 1'b0);
      idle(2);
      check("once_idx1", 32'(frame_idx), 32'd1);
      idle(1);
      check("once_pulse_early", 32'(done_pulse), 32'd0);
      idle(1);
      check("once_idx2", 32'(frame_idx), 32'd2);
      check("once_pulse", 32'(done_pulse), 32'd1);
      peek(3'd4, val);
      check("once_status_done", 32'(val[16]), 32'd1);
      idle(1);
      check("once_pulse_cleared", 32'(done_pulse), 32'd0);
      idle(4);
      check("once_hold", 32'(frame_idx), 32'd2);
      writeReg(3'd0, 32'h3);
      check("once_restart_idx", 32'(frame_idx), 32'd0);
      check("once_restart_base", 32'(frame_base), 32'd0);
      idle(2);
      check("once_running_again", 32'(frame_idx), 32'd1);

      $display("[TB] PINGPONG N=3 P=2");
      setup(2'd2, 32'd2, 32'd3, 1'b0);
      for (int i = 0; i < 5; i++) begin
         idle(2);
         check($sformatf("pp_idx_%0d", i), 32'(frame_idx), 32'(ppIdx[i]));
         peek(3'd4, val);
         check($sformatf("pp_dir_%0d", i), 32'(val[17]), 32'(ppDir[i]));
      end
      setup(2'd2, 32'd2, 32'd1, 1'b0);
      idle(6);
      check("pp_n1_idx", 32'(frame_idx), 32'd0);

      $display("[TB] pause, step and NFRAMES clamp");
      setup(2'd0, 32'd2, 32'd3, 1'b0);
      idle(4);
      check("pause_pre_idx", 32'(frame_idx), 32'd2);
      writeReg(3'd0, 32'h0);
      idle(5);
      check("pause_frozen", 32'(frame_idx), 32'd2);
      writeReg(3'd3, 32'h0);
      check("step_wrap", 32'(frame_idx), 32'd0);
      writeReg(3'd3, 32'hDEAD);
      check("step_inc", 32'(frame_idx), 32'd1);
      writeReg(3'd2, 32'd2);
      check("nframes_keep", 32'(frame_idx), 32'd1);
      writeReg(3'd2, 32'd1);
      check("nframes_clamp_idx", 32'(frame_idx), 32'd0);
      check("nframes_clamp_base", 32'(frame_base), 32'd0);

      $display("[TB] reset mid-run");
      setup(2'd0, 32'd2, 32'd3, 1'b0);
      idle(3);
      check("midrun_pre", 32'(frame_idx), 32'd1);
      #2 reset = 1'b1;
      #1 check("midrun_idx", 32'(frame_idx), 32'd0);
      check("midrun_base", 32'(frame_base), 32'd0);
      peek(3'd1, val);
      check("midrun_period", val, 32'd4166667);
      @(negedge clk);
      reset = 1'b0;
      checkOutput();

`ifdef ANIM_REV_SYNC_EN
      $display("[TB] rev_sync P=10");
      setup(2'd0, 32'd10, 32'd3, 1'b1);
      idle(9);
      peek(3'd4, val);
      check("rev_not_pending", 32'(val[18]), 32'd0);
      idle(1);
      peek(3'd4, val);
      check("rev_pending", 32'(val[18]), 32'd1);
      check("rev_deferred_idx", 32'(frame_idx), 32'd0);
      idle(4);
      check("rev_still_waiting", 32'(frame_idx), 32'd0);
      applyStimulus(1'b0, 3'd4, 32'd0, 1'b1);
      check("rev_advance", 32'(frame_idx), 32'd1);
      peek(3'd4, val);
      check("rev_pending_cleared", 32'(val[18]), 32'd0);
      idle(5);
      check("rev_no_double", 32'(frame_idx), 32'd1);
`else
      $display("[TB] rev_sync disabled build");
      doReset();
      writeReg(3'd0, 32'h9);
      peek(3'd0, val);
      check("ctrl_bit3_ignored", val, 32'h1);
      applyStimulus(1'b0, 3'd4, 32'd0, 1'b1);
      peek(3'd4, val);
      check("status_pending_zero", 32'(val[18]), 32'd0);
`endif

      $display("[TB] randomized run");
      doReset();
      for (int i = 0; i < 3000; i++) begin
         rWe   = ($urandom_range(0, 5) == 0);
         rAddr = 3'($urandom_range(0, 5));
         case (rAddr)
            3'd0:    rData = {28'd0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0)};
            3'd1:    rData = 32'($urandom_range(0, 5));
            3'd2:    rData = 32'($urandom_range(0, 6));
            default: rData = $urandom;
         endcase
         rTick = ($urandom_range(0, 4) == 0);
         applyStimulus(rWe, rAddr, rData, rTick);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
